// File: rtl/body_rate_controller.sv
// Purpose: per-axis rate loop (PD on pitch/roll, P on yaw, throttle pass-through) with output clamping.
// Latency: complete_signal pulses in the 4th cycle after the edge that captures start_signal.
// Backpressure: none; start_signal is only honoured in WAITING, so pulses that arrive mid-run are dropped.
module body_rate_controller #(
    parameter int PR_KP        = 24,
    parameter int PR_KD        = 8,
    parameter int PR_SHIFT     = 4,
    parameter int YAW_KP       = 16,
    parameter int YAW_SHIFT    = 4,
    parameter int RATE_LIMIT   = 3200,
    parameter int THROTTLE_MAX = 4000
) (
    input  logic        us_clk,
    input  logic        resetn,
    input  logic        start_signal,
    input  logic [15:0] throttle_rate_target,
    input  logic [15:0] yaw_rate_target,
    input  logic [15:0] pitch_rate_target,
    input  logic [15:0] roll_rate_target,
    input  logic [15:0] yaw_rate_actual,
    input  logic [15:0] pitch_rate_actual,
    input  logic [15:0] roll_rate_actual,
    output logic [15:0] throttle_out,
    output logic [15:0] yaw_out,
    output logic [15:0] pitch_out,
    output logic [15:0] roll_out,
    output logic        active_signal,
    output logic        complete_signal
);

    // One-hot run sequence.
    localparam logic [4:0] WAITING  = 5'b00001;
    localparam logic [4:0] ERROR    = 5'b00010;
    localparam logic [4:0] SCALE    = 5'b00100;
    localparam logic [4:0] LIMIT    = 5'b01000;
    localparam logic [4:0] COMPLETE = 5'b10000;

    logic [4:0] state;

    // Input snapshot taken when a run is accepted.
    logic [15:0] throttle_tgt_q;
    logic [15:0] yaw_tgt_q;
    logic [15:0] pitch_tgt_q;
    logic [15:0] roll_tgt_q;
    logic [15:0] yaw_act_q;
    logic [15:0] pitch_act_q;
    logic [15:0] roll_act_q;

    // Error stage results.
    logic signed [31:0] yaw_err;
    logic signed [31:0] pitch_err;
    logic signed [31:0] roll_err;
    logic signed [31:0] pitch_delta;
    logic signed [31:0] roll_delta;

    // Derivative history, survives between runs.
    logic signed [31:0] pitch_prev;
    logic signed [31:0] roll_prev;

    // Unclamped commands.
    logic signed [31:0] throttle_cmd;
    logic signed [31:0] yaw_cmd;
    logic signed [31:0] pitch_cmd;
    logic signed [31:0] roll_cmd;

    // Combinational error terms feeding the ERROR stage registers.
    logic signed [31:0] yaw_err_c;
    logic signed [31:0] pitch_err_c;
    logic signed [31:0] roll_err_c;
    logic signed [31:0] pitch_delta_c;
    logic signed [31:0] roll_delta_c;

    function automatic logic signed [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Both gain paths are shifted separately so each term truncates on its own.
    function automatic logic signed [31:0] pd_law(input logic signed [31:0] err,
                                                  input logic signed [31:0] delta);
        return ((err * PR_KP) >>> PR_SHIFT) + ((delta * PR_KD) >>> PR_SHIFT);
    endfunction

    function automatic logic signed [31:0] p_law(input logic signed [31:0] err);
        return (err * YAW_KP) >>> YAW_SHIFT;
    endfunction

    // Compare at full width, then keep only the 12.4 result bits.
    function automatic logic [15:0] clamp16(input logic signed [31:0] v,
                                            input logic signed [31:0] lo,
                                            input logic signed [31:0] hi);
        if (v > hi) begin
            return hi[15:0];
        end else if (v < lo) begin
            return lo[15:0];
        end else begin
            return v[15:0];
        end
    endfunction

    // Rate errors and derivative deltas from the captured snapshot.
    always_comb begin
        yaw_err_c     = sext16(yaw_tgt_q)   - sext16(yaw_act_q);
        pitch_err_c   = sext16(pitch_tgt_q) - sext16(pitch_act_q);
        roll_err_c    = sext16(roll_tgt_q)  - sext16(roll_act_q);
        pitch_delta_c = pitch_err_c - pitch_prev;
        roll_delta_c  = roll_err_c  - roll_prev;
    end

    // Handshake flags decode straight from the one-hot state.
    assign active_signal   = (state == ERROR) || (state == SCALE) || (state == LIMIT);
    assign complete_signal = (state == COMPLETE);

    // State sequencing; an illegal encoding falls back to WAITING.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state <= WAITING;
        end else begin
            case (state)
                WAITING:  state <= start_signal ? ERROR : WAITING;
                ERROR:    state <= SCALE;
                SCALE:    state <= LIMIT;
                LIMIT:    state <= COMPLETE;
                COMPLETE: state <= WAITING;
                default:  state <= WAITING;
            endcase
        end
    end

    // Datapath: capture, error, scale, limit; outputs move only on the LIMIT edge.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            throttle_tgt_q <= '0;
            yaw_tgt_q      <= '0;
            pitch_tgt_q    <= '0;
            roll_tgt_q     <= '0;
            yaw_act_q      <= '0;
            pitch_act_q    <= '0;
            roll_act_q     <= '0;
            yaw_err        <= '0;
            pitch_err      <= '0;
            roll_err       <= '0;
            pitch_delta    <= '0;
            roll_delta     <= '0;
            pitch_prev     <= '0;
            roll_prev      <= '0;
            throttle_cmd   <= '0;
            yaw_cmd        <= '0;
            pitch_cmd      <= '0;
            roll_cmd       <= '0;
            throttle_out   <= '0;
            yaw_out        <= '0;
            pitch_out      <= '0;
            roll_out       <= '0;
        end else begin
            case (state)
                WAITING: begin
                    if (start_signal) begin
                        throttle_tgt_q <= throttle_rate_target;
                        yaw_tgt_q      <= yaw_rate_target;
                        pitch_tgt_q    <= pitch_rate_target;
                        roll_tgt_q     <= roll_rate_target;
                        yaw_act_q      <= yaw_rate_actual;
                        pitch_act_q    <= pitch_rate_actual;
                        roll_act_q     <= roll_rate_actual;
                    end
                end
                ERROR: begin
                    yaw_err     <= yaw_err_c;
                    pitch_err   <= pitch_err_c;
                    roll_err    <= roll_err_c;
                    pitch_delta <= pitch_delta_c;
                    roll_delta  <= roll_delta_c;
                end
                SCALE: begin
                    throttle_cmd <= sext16(throttle_tgt_q);
                    yaw_cmd      <= p_law(yaw_err);
                    pitch_cmd    <= pd_law(pitch_err, pitch_delta);
                    roll_cmd     <= pd_law(roll_err, roll_delta);
                end
                LIMIT: begin
                    throttle_out <= clamp16(throttle_cmd, 0, THROTTLE_MAX);
                    yaw_out      <= clamp16(yaw_cmd,   -RATE_LIMIT, RATE_LIMIT);
                    pitch_out    <= clamp16(pitch_cmd, -RATE_LIMIT, RATE_LIMIT);
                    roll_out     <= clamp16(roll_cmd,  -RATE_LIMIT, RATE_LIMIT);
                    pitch_prev   <= pitch_err;
                    roll_prev    <= roll_err;
                end
                COMPLETE: begin
                end
                default: begin
                    throttle_out <= '0;
                    yaw_out      <= '0;
                    pitch_out    <= '0;
                    roll_out     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_body_rate_controller.sv
// Directed bench for body_rate_controller: hand-computed vectors, immediate-assertion checks.
// Inputs are driven and outputs sampled on the falling edge of us_clk.
// All waits on the DUT are bounded by cycle counts.
module tb_body_rate_controller;

    logic        us_clk;
    logic        resetn;
    logic        start_signal;
    logic [15:0] throttle_rate_target;
    logic [15:0] yaw_rate_target;
    logic [15:0] pitch_rate_target;
    logic [15:0] roll_rate_target;
    logic [15:0] yaw_rate_actual;
    logic [15:0] pitch_rate_actual;
    logic [15:0] roll_rate_actual;
    logic [15:0] throttle_out;
    logic [15:0] yaw_out;
    logic [15:0] pitch_out;
    logic [15:0] roll_out;
    logic        active_signal;
    logic        complete_signal;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    body_rate_controller dut (
        .us_clk               (us_clk),
        .resetn               (resetn),
        .start_signal         (start_signal),
        .throttle_rate_target (throttle_rate_target),
        .yaw_rate_target      (yaw_rate_target),
        .pitch_rate_target    (pitch_rate_target),
        .roll_rate_target     (roll_rate_target),
        .yaw_rate_actual      (yaw_rate_actual),
        .pitch_rate_actual    (pitch_rate_actual),
        .roll_rate_actual     (roll_rate_actual),
        .throttle_out         (throttle_out),
        .yaw_out              (yaw_out),
        .pitch_out            (pitch_out),
        .roll_out             (roll_out),
        .active_signal        (active_signal),
        .complete_signal      (complete_signal)
    );

    initial us_clk = 1'b0;
    always #5 us_clk = ~us_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [15:0] thr, input logic [15:0] yaw,
                              input logic [15:0] pitch, input logic [15:0] roll);
        check({tag, "_throttle"}, {16'h0, throttle_out}, {16'h0, thr});
        check({tag, "_yaw"},      {16'h0, yaw_out},      {16'h0, yaw});
        check({tag, "_pitch"},    {16'h0, pitch_out},    {16'h0, pitch});
        check({tag, "_roll"},     {16'h0, roll_out},     {16'h0, roll});
    endtask

    task automatic set_inputs(input logic [15:0] thr, input logic [15:0] yt, input logic [15:0] pt,
                              input logic [15:0] rt, input logic [15:0] ya, input logic [15:0] pa,
                              input logic [15:0] ra);
        throttle_rate_target = thr;
        yaw_rate_target      = yt;
        pitch_rate_target    = pt;
        roll_rate_target     = rt;
        yaw_rate_actual      = ya;
        pitch_rate_actual    = pa;
        roll_rate_actual     = ra;
    endtask

    // One start pulse; verifies active during the run, complete exactly 4 cycles after capture, one cycle wide.
    task automatic do_run(input string tag, input logic [15:0] thr, input logic [15:0] yt,
                          input logic [15:0] pt, input logic [15:0] rt, input logic [15:0] ya,
                          input logic [15:0] pa, input logic [15:0] ra);
        int n;
        @(negedge us_clk);
        set_inputs(thr, yt, pt, rt, ya, pa, ra);
        start_signal = 1'b1;
        @(negedge us_clk);
        start_signal = 1'b0;
        n = 1;
        check({tag, "_active"}, {31'h0, active_signal}, 32'h1);
        while (complete_signal !== 1'b1 && n < 12) begin
            @(negedge us_clk);
            n++;
        end
        check({tag, "_latency"}, n, 32'd4);
        @(negedge us_clk);
        check({tag, "_complete_width"}, {31'h0, complete_signal}, 32'h0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge us_clk);
        resetn = 1'b0;
        #1;
        check_outs({tag, "_rst"}, 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge us_clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic seen_complete;
        logic seen_active;
        int   ncomp;
        int   first_idx;
        int   second_idx;

        resetn       = 1'b0;
        start_signal = 1'b0;
        set_inputs(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

        // Reset then idle.
        repeat (3) @(negedge us_clk);
        check_outs("reset", 16'h0, 16'h0, 16'h0, 16'h0);
        check("reset_active", {31'h0, active_signal}, 32'h0);
        check("reset_complete", {31'h0, complete_signal}, 32'h0);
        resetn = 1'b1;
        seen_complete = 1'b0;
        seen_active   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge us_clk);
            seen_complete = seen_complete | complete_signal;
            seen_active   = seen_active | active_signal;
        end
        check("idle_no_complete", {31'h0, seen_complete}, 32'h0);
        check("idle_no_active", {31'h0, seen_active}, 32'h0);
        check_outs("idle", 16'h0, 16'h0, 16'h0, 16'h0);

        // First run: P = 240, D = 80.
        do_run("run1", 16'h0, 16'h0, 16'd160, 16'h0, 16'h0, 16'h0, 16'h0);
        check_outs("run1", 16'h0, 16'h0, 16'h0140, 16'h0);

        // Same inputs: delta 0 -> P only.
        do_run("run2", 16'h0, 16'h0, 16'd160, 16'h0, 16'h0, 16'h0, 16'h0);
        check_outs("run2", 16'h0, 16'h0, 16'h00F0, 16'h0);

        // Yaw P law: err -160 -> -160.
        do_run("yaw", 16'h0, 16'hFFB0, 16'd160, 16'h0, 16'h0050, 16'h0, 16'h0);
        check_outs("yaw", 16'h0, 16'hFF60, 16'h00F0, 16'h0);

        // Positive clamp on roll.
        pulse_reset("clampp");
        do_run("clampp", 16'h0, 16'h0, 16'h0, 16'h7FF0, 16'h0, 16'h0, 16'h8010);
        check_outs("clampp", 16'h0, 16'h0, 16'h0, 16'h0C80);

        // Negative clamp on roll with fresh history.
        pulse_reset("clampn");
        do_run("clampn", 16'h0, 16'h0, 16'h0, 16'h8010, 16'h0, 16'h0, 16'h7FF0);
        check_outs("clampn", 16'h0, 16'h0, 16'h0, 16'hF380);

        // Throttle clamps and pass-through.
        pulse_reset("thr");
        do_run("thr_hi", 16'd5000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        check_outs("thr_hi", 16'h0FA0, 16'h0, 16'h0, 16'h0);
        do_run("thr_neg", 16'hFFF0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        check_outs("thr_neg", 16'h0, 16'h0, 16'h0, 16'h0);
        do_run("thr_mid", 16'd1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        check_outs("thr_mid", 16'd1234, 16'h0, 16'h0, 16'h0);

        // Start pulse while busy is dropped.
        @(negedge us_clk);
        set_inputs(16'h0, 16'h0, 16'd160, 16'h0, 16'h0, 16'h0, 16'h0);
        start_signal = 1'b1;
        ncomp = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge us_clk);
            if (i == 1) start_signal = 1'b0;
            if (i == 2) start_signal = 1'b1;
            if (i == 3) start_signal = 1'b0;
            if (complete_signal === 1'b1) ncomp++;
        end
        check("busy_one_complete", ncomp, 32'd1);
        check_outs("busy", 16'h0, 16'h0, 16'h0140, 16'h0);

        // Held start: a new run every 5 cycles.
        @(negedge us_clk);
        start_signal = 1'b1;
        first_idx  = 0;
        second_idx = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge us_clk);
            if (complete_signal === 1'b1) begin
                if (first_idx == 0) first_idx = i;
                else if (second_idx == 0) second_idx = i;
            end
        end
        start_signal = 1'b0;
        repeat (10) @(negedge us_clk);
        check("held_first", first_idx, 32'd4);
        check("held_interval", second_idx - first_idx, 32'd5);
        check_outs("held", 16'h0, 16'h0, 16'h00F0, 16'h0);

        // Reset in SCALE: no completion, outputs and history cleared.
        @(negedge us_clk);
        set_inputs(16'd100, 16'h0, 16'd160, 16'h0, 16'h0, 16'h0, 16'h0);
        start_signal = 1'b1;
        @(negedge us_clk);
        start_signal = 1'b0;
        @(negedge us_clk);
        resetn = 1'b0;
        #1;
        check_outs("midrst", 16'h0, 16'h0, 16'h0, 16'h0);
        check("midrst_active", {31'h0, active_signal}, 32'h0);
        @(negedge us_clk);
        resetn = 1'b1;
        seen_complete = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge us_clk);
            seen_complete = seen_complete | complete_signal;
        end
        check("midrst_no_complete", {31'h0, seen_complete}, 32'h0);
        do_run("after_rst", 16'h0, 16'h0, 16'd160, 16'h0, 16'h0, 16'h0, 16'h0);
        check_outs("after_rst", 16'h0, 16'h0, 16'h0140, 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
